// File: rtl/pmu_ctrl.sv
// Performance-monitor sequencer: clears, runs, snapshots and reads out a
// bank of external 32-bit event counters plus an internal cycle counter.
module pmu_ctrl #(
    parameter int NUM_CNT = 2,
    parameter int WIN_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIN_W-1:0]      cmd_window,
    input  logic [32*NUM_CNT-1:0] cnt_in,
    output logic                  cnt_en,
    output logic                  cnt_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int IDX_W = (NUM_CNT < 1) ? 1 : $clog2(NUM_CNT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_SNAP,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIN_W-1:0]  win;
    logic [31:0]       cycle_cnt;
    logic [31:0]       cyc_shadow;
    logic [31:0]       shadow [NUM_CNT];
    logic [IDX_W-1:0]  idx;
    logic              clr_pend;
    logic              cmd_fire;
    logic              win_done;

    // Commands are only taken while idle or counting.
    assign cmd_ready = (state == S_IDLE) || (state == S_RUN);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cnt_clr   = (state == S_CLR) || clr_pend;

    // The current RUN cycle is the W-th one when the count is about to reach W.
    assign win_done  = (win != '0) && ((cycle_cnt + 32'd1) == 32'(win));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all state-derived outputs, including the readout mux.
    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (cmd_fire && cmd_op == OP_START) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                cnt_en = 1'b1;
                if ((cmd_fire && cmd_op == OP_STOP) || win_done) begin
                    state_nxt = S_SNAP;
                end
            end
            S_SNAP: begin
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx == LAST_IDX);
                out_data  = cyc_shadow;
                for (int k = 0; k < NUM_CNT; k++) begin
                    if (idx == IDX_W'(k + 1)) begin
                        out_data = shadow[k];
                    end
                end
                if (out_ready && out_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Window latch, cycle counter and the one-shot clear request from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= '0;
            cycle_cnt <= '0;
            clr_pend  <= 1'b0;
        end else begin
            clr_pend <= (state == S_IDLE) && cmd_fire && (cmd_op == OP_CLEAR);
            if (state == S_IDLE && cmd_fire && cmd_op == OP_START) begin
                win <= cmd_window;
            end
            if (state == S_CLR) begin
                cycle_cnt <= '0;
            end else if (state == S_RUN && cycle_cnt != 32'hFFFF_FFFF) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

    // Snapshot capture in SNAP and the readout word index during DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_shadow <= '0;
            idx        <= '0;
            for (int k = 0; k < NUM_CNT; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            if (state == S_SNAP) begin
                cyc_shadow <= cycle_cnt;
                idx        <= '0;
                for (int k = 0; k < NUM_CNT; k++) begin
                    shadow[k] <= cnt_in[32*k +: 32];
                end
            end else if (state == S_DRAIN && out_ready) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule
